// File: rtl/xpb_reduce_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : xpb_reduce_seq_if
// Description : Start/result handshake and LUT request bundle for xpb_reduce_seq.
// Revision    : 1.0 - initial release
// ============================================================================
interface xpb_reduce_seq_if #(
    parameter int NUM_DIGITS = 8,
    parameter int DIGIT_W    = 5,
    parameter int XPB_W      = 1024,
    parameter int SEL_W      = $clog2(NUM_DIGITS),
    parameter int ACC_W      = XPB_W + SEL_W + 1
);
    logic                          start;
    logic [NUM_DIGITS*DIGIT_W-1:0] digits_in;
    logic                          busy;
    logic                          lut_req;
    logic [SEL_W-1:0]              lut_sel;
    logic [DIGIT_W-1:0]            lut_digit;
    logic [XPB_W-1:0]              lut_data;
    logic [ACC_W-1:0]              result;
    logic                          result_valid;
    logic                          result_ready;

    modport slave (
        input  start, digits_in, lut_data, result_ready,
        output busy, lut_req, lut_sel, lut_digit, result, result_valid
    );

    modport master (
        output start, digits_in, lut_data, result_ready,
        input  busy, lut_req, lut_sel, lut_digit, result, result_valid
    );
endinterface
`default_nettype wire

// File: rtl/xpb_reduce_seq.sv
`default_nettype none
// ============================================================================
// Module      : xpb_reduce_seq
// Description : Serialises digits onto a shared xpb LUT port and sums the
//               returned values. Optional macro XPB_SKIP_ZERO_EN skips zero digits.
// Revision    : 1.0 - initial release
// ============================================================================
module xpb_reduce_seq #(
    parameter int NUM_DIGITS = 8,
    parameter int DIGIT_W    = 5,
    parameter int XPB_W      = 1024,
    parameter int LUT_LAT    = 1,
    parameter int SEL_W      = $clog2(NUM_DIGITS),
    parameter int ACC_W      = XPB_W + SEL_W + 1
) (
    input  wire logic         clk,
    input  wire logic         reset,
    xpb_reduce_seq_if.slave   bus
);
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;
    localparam int         c_idx_w    = SEL_W + 1;

    logic [1:0]                    r_state;
    logic [NUM_DIGITS*DIGIT_W-1:0] r_digits;
    logic [c_idx_w-1:0]            r_idx;
    logic [ACC_W-1:0]              r_acc;
    logic                          r_busy;
    logic                          r_lut_req;
    logic [SEL_W-1:0]              r_lut_sel;
    logic [DIGIT_W-1:0]            r_lut_digit;
    logic [ACC_W-1:0]              r_result;
    logic                          r_result_valid;

    logic                          w_has_issue;
    logic [c_idx_w-1:0]            w_issue_idx;
    logic [DIGIT_W-1:0]            w_issue_digit;
    logic                          w_tag_exit;
    logic                          w_inflight_next;
    logic [ACC_W-1:0]              w_acc_next;

    // Pick the next access from the latched digits at or after r_idx.
    always_comb begin
        w_has_issue   = 1'b0;
        w_issue_idx   = r_idx;
        w_issue_digit = '0;
`ifdef XPB_SKIP_ZERO_EN
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if ((c_idx_w'(i) >= r_idx) && (r_digits[i*DIGIT_W +: DIGIT_W] != '0)) begin
                w_has_issue   = 1'b1;
                w_issue_idx   = c_idx_w'(i);
                w_issue_digit = r_digits[i*DIGIT_W +: DIGIT_W];
            end
        end
`else
        w_has_issue = (r_idx < c_idx_w'(NUM_DIGITS));
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_issue_digit = r_digits[i*DIGIT_W +: DIGIT_W];
            end
        end
`endif
    end

    // Response tags: one bit per outstanding access, exiting when its data is valid.
    generate
        if (LUT_LAT == 0) begin : g_tag_comb
            assign w_tag_exit      = r_lut_req;
            assign w_inflight_next = 1'b0;
        end else begin : g_tag_pipe
            logic [LUT_LAT-1:0] r_tag;
            logic [LUT_LAT:0]   w_shift;

            assign w_shift         = {r_tag, r_lut_req};
            assign w_tag_exit      = r_tag[LUT_LAT-1];
            assign w_inflight_next = |w_shift[LUT_LAT-1:0];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_tag <= '0;
                end else begin
                    r_tag <= w_shift[LUT_LAT-1:0];
                end
            end
        end
    endgenerate

    assign w_acc_next = r_acc + (w_tag_exit ? {{(ACC_W-XPB_W){1'b0}}, bus.lut_data} : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_st_idle;
            r_digits       <= '0;
            r_idx          <= '0;
            r_acc          <= '0;
            r_busy         <= 1'b0;
            r_lut_req      <= 1'b0;
            r_lut_sel      <= '0;
            r_lut_digit    <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_acc <= w_acc_next;
            case (r_state)
                c_st_idle: begin
                    if (bus.start) begin
                        r_digits <= bus.digits_in;
                        r_acc    <= '0;
                        r_idx    <= '0;
                        r_busy   <= 1'b1;
`ifdef XPB_SKIP_ZERO_EN
                        if (bus.digits_in == '0) begin
                            r_state <= c_st_done;
                        end else begin
                            r_state <= c_st_issue;
                        end
`else
                        r_state  <= c_st_issue;
`endif
                    end
                end
                c_st_issue: begin
                    if (w_has_issue) begin
                        r_lut_req   <= 1'b1;
                        r_lut_sel   <= w_issue_idx[SEL_W-1:0];
                        r_lut_digit <= w_issue_digit;
                        r_idx       <= w_issue_idx + 1'b1;
                    end else begin
                        r_lut_req <= 1'b0;
                        if (LUT_LAT > 0) begin
                            r_state <= c_st_drain;
                        end else begin
                            r_state        <= c_st_done;
                            r_result       <= w_acc_next;
                            r_result_valid <= 1'b1;
                        end
                    end
                end
                c_st_drain: begin
                    if (!w_inflight_next) begin
                        r_state        <= c_st_done;
                        r_result       <= w_acc_next;
                        r_result_valid <= 1'b1;
                    end
                end
                c_st_done: begin
`ifdef XPB_SKIP_ZERO_EN
                    // The all-zero shortcut enters here with result_valid still low.
                    if (!r_result_valid) begin
                        r_result       <= r_acc;
                        r_result_valid <= 1'b1;
                    end else if (bus.result_ready) begin
                        r_result_valid <= 1'b0;
                        r_busy         <= 1'b0;
                        r_state        <= c_st_idle;
                    end
`else
                    if (bus.result_ready) begin
                        r_result_valid <= 1'b0;
                        r_busy         <= 1'b0;
                        r_state        <= c_st_idle;
                    end
`endif
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.busy         = r_busy;
    assign bus.lut_req      = r_lut_req;
    assign bus.lut_sel      = r_lut_sel;
    assign bus.lut_digit    = r_lut_digit;
    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;
endmodule
`default_nettype wire

// File: tb/tb_xpb_reduce_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_xpb_reduce_seq
// Description : Self-checking bench for xpb_reduce_seq at LUT latencies 1,0,2,4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xpb_reduce_seq;
    localparam int c_nd  = 8;
    localparam int c_dw  = 5;
    localparam int c_xw  = 1024;
    localparam int c_aw  = 1028;
    localparam int c_ni  = 4;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            2:       return 2;
            default: return 4;
        endcase
    endfunction

    logic clk;
    logic reset;
    bit   max_mode;

    logic [c_ni-1:0] start_v;
    logic [c_ni-1:0] ready_v;
    logic [c_ni-1:0] busy_v;
    logic [c_ni-1:0] req_v;
    logic [39:0]     digits_a [c_ni];
    logic [2:0]      sel_a    [c_ni];
    logic [4:0]      dig_a    [c_ni];
    logic [c_aw-1:0] res_a    [c_ni];
    logic [c_ni-1:0] val_v;

    int total = 0;
    int bad   = 0;

    function automatic logic [c_xw-1:0] lut_f(input logic [2:0] s, input logic [4:0] d);
        if (max_mode) return '1;
        if (d == 5'd0) return '0;
        return c_xw'(s) * 32 + c_xw'(d);
    endfunction

    generate
        for (genvar k = 0; k < c_ni; k++) begin : g_dut
            localparam int LAT = lat_of(k);
            xpb_reduce_seq_if #(.NUM_DIGITS(c_nd), .DIGIT_W(c_dw), .XPB_W(c_xw)) bus ();

            assign bus.start        = start_v[k];
            assign bus.digits_in    = digits_a[k];
            assign bus.result_ready = ready_v[k];
            assign busy_v[k]        = bus.busy;
            assign req_v[k]         = bus.lut_req;
            assign sel_a[k]         = bus.lut_sel;
            assign dig_a[k]         = bus.lut_digit;
            assign res_a[k]         = bus.result;
            assign val_v[k]         = bus.result_valid;

            xpb_reduce_seq #(
                .NUM_DIGITS(c_nd), .DIGIT_W(c_dw), .XPB_W(c_xw), .LUT_LAT(LAT)
            ) u_dut (
                .clk   (clk),
                .reset (reset),
                .bus   (bus.slave)
            );

            if (LAT == 0) begin : g_lut_comb
                assign bus.lut_data = lut_f(bus.lut_sel, bus.lut_digit);
            end else begin : g_lut_pipe
                logic [c_xw-1:0] pipe [LAT];
                always @(posedge clk) begin
                    pipe[0] <= lut_f(bus.lut_sel, bus.lut_digit);
                    for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
                end
                assign bus.lut_data = pipe[LAT-1];
            end
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] rand_digits(input bit allow_zero);
        logic [39:0] d;
        d = '0;
        for (int i = 0; i < c_nd; i++) begin
            if (allow_zero && ($urandom_range(0, 3) == 0)) d[i*5 +: 5] = 5'd0;
            else d[i*5 +: 5] = 5'($urandom_range(1, 31));
        end
        return d;
    endfunction

    // One reduction: reference model, stimulus, access/timing/result checks, handshake.
    task automatic do_run(input int k, input logic [39:0] d, input int hold,
                          input bit scramble, output logic [c_aw-1:0] res_out);
        logic [c_aw-1:0] exp_sum;
        int              exp_sel [16];
        int              exp_dig [16];
        int              exp_n;
        int              exp_cyc;
        int              obs_sel [16];
        int              obs_dig [16];
        int              obs_cyc [16];
        int              obs_n;
        int              cyc;
        bit              got;
        bit              issue_it;
        int              di;
        logic [63:0]     junk;

        exp_sum = '0;
        exp_n   = 0;
        for (int i = 0; i < c_nd; i++) begin
            di = int'(d[i*5 +: 5]);
`ifdef XPB_SKIP_ZERO_EN
            issue_it = (di != 0);
`else
            issue_it = 1'b1;
`endif
            if (issue_it) begin
                exp_sel[exp_n] = i;
                exp_dig[exp_n] = di;
                exp_n++;
                if (max_mode) exp_sum = exp_sum + {4'd0, {c_xw{1'b1}}};
                else if (di != 0) exp_sum = exp_sum + c_aw'(i * 32 + di);
            end
        end
        exp_cyc = (exp_n == 0) ? 1 : exp_n + 1 + lat_of(k);

        digits_a[k] = d;
        ready_v[k]  = 1'b0;
        start_v[k]  = 1'b1;
        tick();
        start_v[k] = 1'b0;
        if (scramble) begin
            junk = {$urandom, $urandom};
            digits_a[k] = junk[39:0];
        end
        total++;
        if (busy_v[k] !== 1'b1) begin
            bad++;
            $display("FAIL accept_busy k=%0d got=%b want=1", k, busy_v[k]);
        end

        cyc   = 0;
        obs_n = 0;
        got   = 1'b0;
        while (!got && cyc < 60) begin
            tick();
            cyc++;
            if (req_v[k] === 1'b1 && obs_n < 16) begin
                obs_sel[obs_n] = int'(sel_a[k]);
                obs_dig[obs_n] = int'(dig_a[k]);
                obs_cyc[obs_n] = cyc;
                obs_n++;
            end
            if (val_v[k] === 1'b1) got = 1'b1;
        end

        total++;
        if (!got) begin
            bad++;
            $display("FAIL valid_timeout k=%0d got=no_valid want=valid_by_%0d", k, exp_cyc);
        end
        total++;
        if (cyc != exp_cyc) begin
            bad++;
            $display("FAIL valid_cycle k=%0d got=%0d want=%0d", k, cyc, exp_cyc);
        end
        total++;
        if (obs_n != exp_n) begin
            bad++;
            $display("FAIL access_count k=%0d got=%0d want=%0d", k, obs_n, exp_n);
        end
        for (int j = 0; j < exp_n && j < obs_n; j++) begin
            total++;
            if (obs_sel[j] != exp_sel[j] || obs_dig[j] != exp_dig[j] || obs_cyc[j] != j + 1) begin
                bad++;
                $display("FAIL access k=%0d j=%0d got=sel%0d/dig%0d/cyc%0d want=sel%0d/dig%0d/cyc%0d",
                         k, j, obs_sel[j], obs_dig[j], obs_cyc[j], exp_sel[j], exp_dig[j], j + 1);
            end
        end
        total++;
        if (res_a[k] !== exp_sum) begin
            bad++;
            $display("FAIL result k=%0d got=%0h want=%0h", k, res_a[k], exp_sum);
        end
        res_out = res_a[k];

        for (int h = 0; h < hold; h++) begin
            start_v[k]  = (h == hold / 2);
            digits_a[k] = rand_digits(1'b0);
            tick();
            total++;
            if (val_v[k] !== 1'b1 || res_a[k] !== exp_sum || busy_v[k] !== 1'b1) begin
                bad++;
                $display("FAIL hold k=%0d h=%0d got=v%b/b%b/%0h want=v1/b1/%0h",
                         k, h, val_v[k], busy_v[k], res_a[k], exp_sum);
            end
        end
        start_v[k] = 1'b0;

        ready_v[k] = 1'b1;
        tick();
        ready_v[k] = 1'b0;
        total++;
        if (busy_v[k] !== 1'b0 || val_v[k] !== 1'b0) begin
            bad++;
            $display("FAIL handshake k=%0d got=b%b/v%b want=b0/v0", k, busy_v[k], val_v[k]);
        end
        if (hold > 0) begin
            tick();
            total++;
            if (busy_v[k] !== 1'b0 || req_v[k] !== 1'b0) begin
                bad++;
                $display("FAIL start_not_queued k=%0d got=b%b/r%b want=b0/r0", k, busy_v[k], req_v[k]);
            end
        end
    endtask

    task automatic check_zero(input int k, input string tag);
        total++;
        if (busy_v[k] !== 1'b0 || req_v[k] !== 1'b0 || sel_a[k] !== 3'd0 ||
            dig_a[k] !== 5'd0 || res_a[k] !== '0 || val_v[k] !== 1'b0) begin
            bad++;
            $display("FAIL %s k=%0d got=b%b/r%b/s%0d/d%0d/v%b/res%0h want=all_zero",
                     tag, k, busy_v[k], req_v[k], sel_a[k], dig_a[k], val_v[k], res_a[k]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < c_ni; k++) check_zero(k, "reset_state");
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [c_aw-1:0] r;
        do_run(0, {8{5'd1}}, 0, 1'b1, r);
        total++;
        if (r !== c_aw'(904)) begin
            bad++;
            $display("FAIL basic_904 got=%0d want=904", r);
        end
    endtask

    task automatic test_latency();
        logic [c_aw-1:0] r;
        for (int k = 1; k < c_ni; k++) begin
            do_run(k, {8{5'd31}}, 0, 1'b0, r);
            total++;
            if (r !== c_aw'(1144)) begin
                bad++;
                $display("FAIL latency_1144 k=%0d got=%0d want=1144", k, r);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [c_aw-1:0] r;
        do_run(0, rand_digits(1'b0), 20, 1'b0, r);
    endtask

    task automatic test_back_to_back();
        logic [c_aw-1:0] r;
        do_run(2, rand_digits(1'b1), 0, 1'b1, r);
        do_run(2, rand_digits(1'b1), 0, 1'b1, r);
        do_run(2, rand_digits(1'b0), 0, 1'b0, r);
    endtask

    task automatic test_random();
        logic [c_aw-1:0] r;
        for (int n = 0; n < 8; n++) begin
            do_run(int'($urandom_range(0, c_ni - 1)), rand_digits(1'b1), 0, 1'b1, r);
        end
    endtask

    task automatic test_reset_mid();
        logic [c_aw-1:0] r;
        digits_a[3] = rand_digits(1'b0);
        start_v[3]  = 1'b1;
        tick();
        start_v[3] = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero(3, "reset_mid");
        do_run(3, {8{5'd2}}, 0, 1'b0, r);
        total++;
        if (r !== c_aw'(912)) begin
            bad++;
            $display("FAIL reset_mid_912 got=%0d want=912", r);
        end
    endtask

    task automatic test_max();
        logic [c_aw-1:0] r;
        logic [11:0]     top;
        max_mode = 1'b1;
        do_run(3, rand_digits(1'b0), 0, 1'b0, r);
        max_mode = 1'b0;
        top = r[c_aw-1 -: 12];
        total++;
        if (top !== 12'h7FF || r[3:0] !== 4'h8) begin
            bad++;
            $display("FAIL max_msb got=top%0h/low%0h want=top7ff/low8", top, r[3:0]);
        end
    endtask

    task automatic test_skip_zero();
        logic [c_aw-1:0] r;
        do_run(0, (40'd5 << 5) | (40'd7 << 20), 0, 1'b0, r);
        total++;
        if (r !== c_aw'(172)) begin
            bad++;
            $display("FAIL sparse_172 got=%0d want=172", r);
        end
        do_run(0, 40'd0, 0, 1'b0, r);
        do_run(3, 40'd0, 0, 1'b0, r);
        total++;
        if (r !== '0) begin
            bad++;
            $display("FAIL all_zero got=%0h want=0", r);
        end
    endtask

    initial begin
        reset    = 1'b1;
        max_mode = 1'b0;
        start_v  = '0;
        ready_v  = '0;
        for (int k = 0; k < c_ni; k++) digits_a[k] = '0;

        test_reset();
        test_basic();
        test_latency();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_max();
        test_skip_zero();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
